inta_master: RTL and testbench



---
 rtl/inta_master.sv | 131 +++++++++++++
 tb/tb_inta_master.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inta_master.sv
// inta_master: CPU-side end of the PIC INT/INTA handshake.
//
// On a qualified INT (INT=1 and enable=1, sampled only in IDLE) it drives two
// active-low INTA pulses, latches the vector byte on datain at the last edge of
// the second pulse, and offers it to the CPU core. On request it also writes
// the non-specific EOI command (A0=0, data 8'h20) with an active-low WR pulse.
//
// Handshake: vector_valid rises with the captured vector and stays high, with
// vector stable, until the edge where vector_ready=1; the transfer happens on
// that edge and vector_valid is low afterwards.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   INT, enable       interrupt request from PIC, CPU interrupt-enable flag
//   datain[7:0]       PIC data bus (vector during the second INTA pulse)
//   INTA, WR, A0      active-low acknowledge, active-low write, register select
//   dataout[7:0]      command byte during WR
//   vector[7:0]       captured vector; vector_valid / vector_ready handshake
//   eoi_req           single-cycle request for a non-specific EOI
//   busy              high whenever the controller is not in IDLE
module inta_master #(
  parameter int INTA_LOW_CYCLES = 2,
  parameter int INTA_GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       INT,
  input  logic       enable,
  input  logic [7:0] datain,
  output logic       INTA,
  output logic       WR,
  output logic       A0,
  output logic [7:0] dataout,
  output logic [7:0] vector,
  output logic       vector_valid,
  input  logic       vector_ready,
  input  logic       eoi_req,
  output logic       busy
);

  localparam int MAX_CYC = (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ? INTA_LOW_CYCLES
                                                               : INTA_GAP_CYCLES;
  // The counter holds "cycles remaining minus one", so it only needs MAX_CYC-1.
  localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] LOW_RELOAD = CW'(INTA_LOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_RELOAD = CW'(INTA_GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    P1_LOW = 3'd1,
    GAP    = 3'd2,
    P2_LOW = 3'd3,
    HOLD   = 3'd4,
    EOI_WR = 3'd5
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            last;
  logic            eoi_pending;

  assign last = (cnt == '0);

  // Next-state logic. Once P1_LOW is entered the sequence runs to HOLD
  // regardless of INT/enable, since the PIC expects both pulses.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (eoi_pending)          state_nxt = EOI_WR;
        else if (INT && enable)   state_nxt = P1_LOW;
      end
      P1_LOW:  if (last)          state_nxt = GAP;
      GAP:     if (last)          state_nxt = P2_LOW;
      P2_LOW:  if (last)          state_nxt = HOLD;
      HOLD:    if (vector_ready)  state_nxt = IDLE;
      EOI_WR:  if (last)          state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Duration counter: reloaded on every state entry, counts down to zero.
  always_comb begin
    cnt_nxt = cnt;
    if (state_nxt != state) begin
      case (state_nxt)
        P1_LOW, P2_LOW, EOI_WR: cnt_nxt = LOW_RELOAD;
        GAP:                    cnt_nxt = GAP_RELOAD;
        default:                cnt_nxt = '0;
      endcase
    end else if (!last) begin
      cnt_nxt = cnt - CW'(1);
    end
  end

  // Outputs are registered from the next state, so each pin changes on the
  // same edge as the state it belongs to and has no combinational input path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      INTA         <= 1'b1;
      WR           <= 1'b1;
      A0           <= 1'b1;
      dataout      <= 8'h00;
      vector       <= 8'h00;
      vector_valid <= 1'b0;
      busy         <= 1'b0;
      eoi_pending  <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      INTA         <= !((state_nxt == P1_LOW) || (state_nxt == P2_LOW));
      WR           <= (state_nxt != EOI_WR);
      A0           <= (state_nxt != EOI_WR);
      dataout      <= (state_nxt == EOI_WR) ? 8'h20 : 8'h00;
      vector_valid <= (state_nxt == HOLD);
      busy         <= (state_nxt != IDLE);
      if ((state == P2_LOW) && last)
        vector <= datain;
      // A new request on the exit edge of EOI_WR must not be lost: set wins.
      if (eoi_req)
        eoi_pending <= 1'b1;
      else if ((state == EOI_WR) && last)
        eoi_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inta_master.sv
// Bench for inta_master: a directed cycle table, hand-written corner-case
// sequences and randomized traffic, all checked against a transaction-level
// reference model and an expected-vector queue.
module tb_inta_master;

  localparam int L = 2;
  localparam int G = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       INT = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] datain = 8'h00;
  logic       vector_ready = 1'b0;
  logic       eoi_req = 1'b0;
  logic       INTA, WR, A0, busy, vector_valid;
  logic [7:0] dataout, vector;

  inta_master #(.INTA_LOW_CYCLES(L), .INTA_GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .enable(enable), .datain(datain),
    .INTA(INTA), .WR(WR), .A0(A0), .dataout(dataout), .vector(vector),
    .vector_valid(vector_valid), .vector_ready(vector_ready),
    .eoi_req(eoi_req), .busy(busy)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wr_falls = 0;
  logic prev_wr = 1'b1;

  // ---------------- reference model ----------------
  // Phases: 0 idle, 1 acknowledge pulses, 2 holding vector, 3 EOI write.
  // During phase 1, m_q holds the INTA level for each upcoming cycle.
  int         m_phase = 0;
  bit         m_q[$];
  int         m_wr_left = 0;
  bit         m_pend = 0;
  logic [7:0] m_vec = 8'h00;
  bit         m_valid = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_phase = 0; m_q.delete(); m_wr_left = 0; m_pend = 0;
      m_vec = 8'h00; m_valid = 0; exp_q.delete();
    end else begin
      case (m_phase)
        0: begin
          if (m_pend) begin
            m_phase = 3; m_wr_left = L;
          end else if (INT && enable) begin
            m_phase = 1;
            m_q.delete();
            repeat (L) m_q.push_back(1'b0);
            repeat (G) m_q.push_back(1'b1);
            repeat (L) m_q.push_back(1'b0);
          end
        end
        1: begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_vec = datain; m_valid = 1; m_phase = 2;
            exp_q.push_back(datain);
          end
        end
        2: if (vector_ready) begin m_valid = 0; m_phase = 0; end
        3: begin
          m_wr_left--;
          if (m_wr_left == 0) begin m_phase = 0; m_pend = 0; end
        end
        default: m_phase = 0;
      endcase
      if (eoi_req) m_pend = 1;
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic drive(input logic r, input logic i, input logic e,
                       input logic [7:0] d, input logic rd, input logic eo);
    logic [7:0] exp;
    rst_n = r; INT = i; enable = e; datain = d; vector_ready = rd; eoi_req = eo;
    // A transfer happens on the coming edge: score it against the queue.
    if (r && vector_valid && vector_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL accept cyc=%0d got vector=%h but none expected", cyc, vector);
      end else begin
        exp = exp_q.pop_front();
        if (vector !== exp) begin
          bad++;
          $display("FAIL accept cyc=%0d got vector=%h exp=%h", cyc, vector, exp);
        end
      end
    end
  endtask

  task automatic check_model();
    logic [20:0] got, exp;
    logic        e_inta;
    e_inta = (m_phase == 1) ? m_q[0] : 1'b1;
    exp = {e_inta, (m_phase != 3), (m_phase != 3),
           (m_phase == 3) ? 8'h20 : 8'h00, m_vec, m_valid, (m_phase != 0)};
    got = {INTA, WR, A0, dataout, vector, vector_valid, busy};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL model cyc=%0d got {inta,wr,a0,dout,vec,valid,busy}=%h exp=%h",
               cyc, got, exp);
    end
    total++;
    if (!INTA && !WR) begin
      bad++;
      $display("FAIL excl cyc=%0d got INTA=0 WR=0 exp not both low", cyc);
    end
    if (prev_wr === 1'b1 && WR === 1'b0) wr_falls++;
    prev_wr = WR;
  endtask

  task automatic step(input logic r, input logic i, input logic e,
                      input logic [7:0] d, input logic rd, input logic eo);
    drive(r, i, e, d, rd, eo);
    @(negedge clk);
    check_model();
  endtask

  task automatic check_count(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       r, i, e;
    logic [7:0] d;
    logic       rd, eo;
    logic       e_inta, e_wr, e_valid, e_busy;
    logic [7:0] e_vec;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // inputs: r i e din rdy eoi | expected after the edge: inta wr valid busy vec
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 8'h48, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 8'h48, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h48};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h48};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h48};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h48};

    @(negedge clk);
    @(negedge clk);
    for (int n = 0; n < 11; n++) begin
      logic [11:0] got, exp;
      drive(tbl[n].r, tbl[n].i, tbl[n].e, tbl[n].d, tbl[n].rd, tbl[n].eo);
      @(negedge clk);
      got = {INTA, WR, vector_valid, busy, vector};
      exp = {tbl[n].e_inta, tbl[n].e_wr, tbl[n].e_valid, tbl[n].e_busy, tbl[n].e_vec};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL table row=%0d got {inta,wr,valid,busy,vec}=%h exp=%h", n, got, exp);
      end
      prev_wr = WR;
    end

    // enable low masks INT for 20 cycles, then the sequence starts next edge
    for (int n = 0; n < 20; n++) step(1, 1, 0, 8'h00, 0, 0);
    step(1, 1, 1, 8'h00, 0, 0);
    check_count("enable_start_inta", int'(INTA), 0);
    for (int n = 0; n < 6; n++) step(1, 0, 1, 8'h5a, 0, 0);
    check_count("enable_vec_valid", int'(vector_valid), 1);
    step(1, 0, 1, 8'h00, 1, 0);

    // EOI requested during GAP, vector accepted at once; WR follows HOLD
    wr_falls = 0;
    step(1, 1, 1, 8'h00, 1, 0);
    step(1, 0, 1, 8'h00, 1, 0);
    step(1, 0, 1, 8'h00, 1, 0);
    step(1, 0, 1, 8'h00, 1, 1);
    for (int n = 0; n < 10; n++) step(1, 0, 1, 8'h33, 1, 0);
    check_count("eoi_gap_wr_pulses", wr_falls, 1);

    // Two EOI requests and INT pending while in HOLD: EOI first, then INTA
    step(1, 1, 1, 8'h00, 0, 0);
    for (int n = 0; n < 6; n++) step(1, 1, 1, 8'h77, 0, 0);
    wr_falls = 0;
    step(1, 1, 1, 8'h00, 0, 1);
    step(1, 1, 1, 8'h00, 0, 1);
    step(1, 1, 1, 8'h00, 1, 0);
    step(1, 1, 1, 8'h00, 1, 0);
    check_count("eoi_first_wr", int'(WR), 0);
    check_count("eoi_first_inta", int'(INTA), 1);
    for (int n = 0; n < 10; n++) step(1, 0, 1, 8'h99, 1, 0);
    check_count("eoi_collapse_pulses", wr_falls, 1);

    // Reset during P2_LOW, with an EOI pending that reset must discard
    step(1, 1, 1, 8'h00, 0, 0);
    step(1, 0, 1, 8'h00, 0, 1);
    step(1, 0, 1, 8'h00, 0, 0);
    step(1, 0, 1, 8'h00, 0, 0);
    step(1, 0, 1, 8'h00, 0, 0);
    wr_falls = 0;
    step(0, 0, 1, 8'hc3, 0, 0);
    check_count("rst_inta", int'(INTA), 1);
    check_count("rst_valid", int'(vector_valid), 0);
    check_count("rst_vector", int'(vector), 0);
    check_count("rst_busy", int'(busy), 0);
    for (int n = 0; n < 10; n++) step(1, 0, 1, 8'h00, 0, 0);
    check_count("rst_no_stale_eoi", wr_falls, 0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 149) != 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) != 0),
           8'($urandom_range(0, 255)),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 19) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
